// File: rtl/cpu_types_pkg.sv
// Machine word and address widths shared across the CPU.
package cpu_types_pkg;
  localparam int unsigned CPU_WORD_W = 32;
  localparam int unsigned CPU_ADDR_W = 32;
endpackage

// File: rtl/diaosi_types_pkg.sv
// Front-end decode types shared by the diaosi core; ADD4..BRANCH keep their original codes.
package diaosi_types_pkg;
  typedef enum logic [2:0] {
    ADD4   = 3'd0,
    JUMP   = 3'd1,
    JR     = 3'd2,
    BRANCH = 3'd3,
    CALL   = 3'd4,
    RET    = 3'd5
  } pcsrc_t;
endpackage

// File: rtl/return_stack.sv
// Circular return-address stack; a push while full silently overwrites the oldest entry.
module return_stack #(
  parameter  int unsigned ADDR_W    = 32,
  parameter  int unsigned RAS_DEPTH = 4,
  localparam int unsigned PTR_W     = $clog2(RAS_DEPTH),
  localparam int unsigned CNT_W     = $clog2(RAS_DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_CNT);
  assign top   = mem_q[wr_ptr_q - PTR_W'(1)];

  // NOTE: every always_comb output gets its default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (!full) count_d = count_q + CNT_W'(1);
    end else if (pop && !empty) begin
      wr_ptr_d = wr_ptr_q - PTR_W'(1);
      count_d  = count_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: entries carry no reset; count_q alone decides which slots are valid.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/fetch_pc_ras.sv
// Fetch PC generator; the return-address stack is built only when FETCH_PC_RAS_EN is defined,
// otherwise CALL behaves as JUMP and RET as JR.
module fetch_pc_ras
  import diaosi_types_pkg::*;
#(
  parameter int unsigned       ADDR_W    = cpu_types_pkg::CPU_ADDR_W,
  parameter int unsigned       RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              pc_next,
  input  pcsrc_t            PCSrc,
  input  logic [15:0]       imm16,
  input  logic [25:0]       j_addr26,
  input  logic [ADDR_W-1:0] jr,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr,
  output logic [ADDR_W-1:0] i_addr,
  output logic              ras_empty,
  output logic              ras_full
);
  logic [ADDR_W-1:0] i_addr_q, i_addr_d;
  logic [ADDR_W-1:0] add4, branch, jump;

  assign add4   = i_addr_q + ADDR_W'(4);
  assign branch = i_addr_q + {{(ADDR_W-16){imm16[15]}}, imm16};

  // At the minimum width the jump field spans the whole address.
  generate
    if (ADDR_W > 28) begin : g_jump_hi
      assign jump = {i_addr_q[ADDR_W-1:28], j_addr26, 2'b00};
    end else begin : g_jump_lo
      assign jump = {j_addr26, 2'b00};
    end
  endgenerate

`ifdef FETCH_PC_RAS_EN
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic              advance, ras_push, ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic [CNT_W-1:0]  ras_count;

  assign advance  = pc_next && !flush;
  assign ras_push = advance && (PCSrc == CALL);
  assign ras_pop  = advance && (PCSrc == RET) && (ras_count != '0);

  return_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_return_stack (
    .CLK       (CLK),
    .RST       (RST),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (add4),
    .top       (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );
`else
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
`endif

  always_comb begin
    i_addr_d = i_addr_q;
    if (flush) begin
      i_addr_d = flush_addr;
    end else if (pc_next) begin
      case (PCSrc)
        ADD4:       i_addr_d = add4;
        JUMP, CALL: i_addr_d = jump;
        BRANCH:     i_addr_d = branch;
`ifdef FETCH_PC_RAS_EN
        JR:         i_addr_d = jr;
        RET:        i_addr_d = ras_empty ? jr : ras_top;
`else
        JR, RET:    i_addr_d = jr;
`endif
        default:    i_addr_d = add4;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) i_addr_q <= RESET_PC;
    else     i_addr_q <= i_addr_d;
  end

  assign i_addr = i_addr_q;
endmodule

// File: tb/tb_fetch_pc_ras.sv
// Scoreboard bench for fetch_pc_ras: the driver queues expected state after each edge,
// a monitor pops and compares on the following falling edge.
module tb_fetch_pc_ras;
  import diaosi_types_pkg::*;

`ifdef FETCH_PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        empty;
    logic        full;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        pc_next = 1'b0;
  pcsrc_t      PCSrc = ADD4;
  logic [15:0] imm16 = '0;
  logic [25:0] j_addr26 = '0;
  logic [31:0] jr = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_addr = '0;
  logic [31:0] i_addr;
  logic        ras_empty, ras_full;
  logic        mon_poke = 1'b0;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  fetch_pc_ras #(
    .ADDR_W    (32),
    .RAS_DEPTH (4),
    .RESET_PC  (32'h0)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .pc_next    (pc_next),
    .PCSrc      (PCSrc),
    .imm16      (imm16),
    .j_addr26   (j_addr26),
    .jr         (jr),
    .flush      (flush),
    .flush_addr (flush_addr),
    .i_addr     (i_addr),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  always @(negedge CLK or posedge mon_poke) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.name, ".i_addr"},    i_addr,          e.addr);
      check({e.name, ".ras_empty"}, 32'(ras_empty),  32'(e.empty));
      check({e.name, ".ras_full"},  32'(ras_full),   32'(e.full));
    end
  end

  // One clock of stimulus followed by the expected registered result.
  task automatic step(input string nm, input pcsrc_t src, input logic pcn,
                      input logic fl, input logic [31:0] fla, input logic [15:0] imm,
                      input logic [25:0] j, input logic [31:0] jrv,
                      input logic [31:0] ea, input logic ee, input logic ef);
    PCSrc = src; pc_next = pcn; flush = fl; flush_addr = fla;
    imm16 = imm; j_addr26 = j; jr = jrv;
    @(posedge CLK);
    sb.push_back('{nm, ea, ee, ef});
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 RST = 1'b1;
    @(posedge CLK);
    sb.push_back('{"reset", 32'h0, 1'b1, 1'b0});
    @(negedge CLK);
    RST = 1'b0;

    // name          src     pcn  fl  flush_addr    imm16     j_addr26     jr            exp addr      empty    full
    step("add4_1",   ADD4,   1, 0, 32'h0,        16'h0,    26'h0,       32'h0,        32'h4,        1'b1,    1'b0);
    step("add4_2",   ADD4,   1, 0, 32'h0,        16'h0,    26'h0,       32'h0,        32'h8,        1'b1,    1'b0);
    step("add4_3",   ADD4,   1, 0, 32'h0,        16'h0,    26'h0,       32'h0,        32'hC,        1'b1,    1'b0);
    step("stall",    JUMP,   0, 0, 32'h0,        16'h0,    26'h3F,      32'h0,        32'hC,        1'b1,    1'b0);
    step("fl_top",   ADD4,   0, 1, 32'hFFFFFFFC, 16'h0,    26'h0,       32'h0,        32'hFFFFFFFC, 1'b1,    1'b0);
    step("wrap",     ADD4,   1, 0, 32'h0,        16'h0,    26'h0,       32'h0,        32'h0,        1'b1,    1'b0);
    step("fl_pri",   JUMP,   1, 1, 32'h100,      16'h0,    26'h3FFFFFF, 32'h0,        32'h100,      1'b1,    1'b0);
    step("br_neg",   BRANCH, 1, 0, 32'h0,        16'hFFF0, 26'h0,       32'h0,        32'hF0,       1'b1,    1'b0);
    step("jump",     JUMP,   1, 0, 32'h0,        16'h0,    26'h40,      32'h0,        32'h100,      1'b1,    1'b0);
    step("undef",    pcsrc_t'(3'd6), 1, 0, 32'h0, 16'h0,   26'h0,       32'h0,        32'h104,      1'b1,    1'b0);
    step("br_pos",   BRANCH, 1, 0, 32'h0,        16'h7FFC, 26'h0,       32'h0,        32'h8100,     1'b1,    1'b0);
    step("jr",       JR,     1, 0, 32'h0,        16'h0,    26'h0,       32'h200,      32'h200,      1'b1,    1'b0);
    step("call",     CALL,   1, 0, 32'h0,        16'h0,    26'h100,     32'h0,        32'h400,      !RAS_ON, 1'b0);
    step("ret_hold", RET,    0, 0, 32'h0,        16'h0,    26'h0,       32'h777,      32'h400,      !RAS_ON, 1'b0);
    step("ret",      RET,    1, 0, 32'h0,        16'h0,    26'h0,       32'h777,      RAS_ON ? 32'h204 : 32'h777, 1'b1, 1'b0);

    // Five nested calls into a four-entry stack, then five returns.
    step("fl_1000",  ADD4,   0, 1, 32'h1000,     16'h0,    26'h0,       32'h0,        32'h1000,     1'b1,    1'b0);
    step("call1",    CALL,   1, 0, 32'h0,        16'h0,    26'h800,     32'h0,        32'h2000,     !RAS_ON, 1'b0);
    step("call2",    CALL,   1, 0, 32'h0,        16'h0,    26'hC00,     32'h0,        32'h3000,     !RAS_ON, 1'b0);
    step("call3",    CALL,   1, 0, 32'h0,        16'h0,    26'h1000,    32'h0,        32'h4000,     !RAS_ON, 1'b0);
    step("call4",    CALL,   1, 0, 32'h0,        16'h0,    26'h1400,    32'h0,        32'h5000,     !RAS_ON, RAS_ON);
    step("call5",    CALL,   1, 0, 32'h0,        16'h0,    26'h1800,    32'h0,        32'h6000,     !RAS_ON, RAS_ON);
    step("ret1",     RET,    1, 0, 32'h0,        16'h0,    26'h0,       32'hABC,      RAS_ON ? 32'h5004 : 32'hABC, !RAS_ON, 1'b0);
    step("ret2",     RET,    1, 0, 32'h0,        16'h0,    26'h0,       32'hABC,      RAS_ON ? 32'h4004 : 32'hABC, !RAS_ON, 1'b0);
    step("ret3",     RET,    1, 0, 32'h0,        16'h0,    26'h0,       32'hABC,      RAS_ON ? 32'h3004 : 32'hABC, !RAS_ON, 1'b0);
    step("ret4",     RET,    1, 0, 32'h0,        16'h0,    26'h0,       32'hABC,      RAS_ON ? 32'h2004 : 32'hABC, 1'b1, 1'b0);
    step("ret5",     RET,    1, 0, 32'h0,        16'h0,    26'h0,       32'hABC,      32'hABC,      1'b1,    1'b0);

    // Flush during a CALL must neither push nor disturb the stack.
    step("call_ac",  CALL,   1, 0, 32'h0,        16'h0,    26'h80,      32'h0,        32'h200,      !RAS_ON, 1'b0);
    step("fl_call",  CALL,   0, 1, 32'h8000,     16'h0,    26'h55,      32'h0,        32'h8000,     !RAS_ON, 1'b0);
    step("ret_fl",   RET,    1, 0, 32'h0,        16'h0,    26'h0,       32'h3330,     RAS_ON ? 32'hAC0 : 32'h3330, 1'b1, 1'b0);

    // Reset asserted partway through a RET cycle.
    step("fl_9000",  ADD4,   0, 1, 32'h9000,     16'h0,    26'h0,       32'h0,        32'h9000,     1'b1,    1'b0);
    step("call_rst", CALL,   1, 0, 32'h0,        16'h0,    26'h10,      32'h0,        32'h40,       !RAS_ON, 1'b0);
    PCSrc = RET; pc_next = 1'b1; flush = 1'b0; jr = 32'h5550;
    #1 RST = 1'b1;
    #1 sb.push_back('{"mid_rst", 32'h0, 1'b1, 1'b0});
    mon_poke = 1'b1;
    #1 mon_poke = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    step("post_rst", ADD4,   1, 0, 32'h0,        16'h0,    26'h0,       32'h0,        32'h4,        1'b1,    1'b0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge CLK);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
